// File: rtl/rf_wb_write_arbiter_pkg.sv
// Shared types and sizes for the register-file writeback write arbiter.
package rf_wb_write_arbiter_pkg;

    localparam int RF_DEPTH = 32;
    localparam int RF_AW    = $clog2(RF_DEPTH);
    localparam int RF_WIDTH = 32;

    typedef struct packed {
        logic [RF_AW-1:0]    addr;
        logic [RF_WIDTH-1:0] data;
    } rf_wb_req_t;

    typedef enum logic {
        RF_WB_INIT,
        RF_WB_RUN
    } rf_wb_state_e;

    function automatic logic [RF_DEPTH-1:0] rf_addr_onehot(input logic [RF_AW-1:0] a);
        return RF_DEPTH'(1) << a;
    endfunction

endpackage

// File: rtl/rf_wb_write_arbiter_fifo2.sv
// Two-entry writeback FIFO; exposes both slots' valid/addr so the top can build the pending mask.
module rf_wb_fifo2
    import rf_wb_write_arbiter_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  rf_wb_req_t                 push_entry,
    input  logic                       pop,
    output logic                       full,
    output logic                       empty,
    output rf_wb_req_t                 head,
    output logic [1:0]                 entry_valid,
    output logic [1:0][RF_AW-1:0]      entry_addr
);

    rf_wb_req_t slots [2];
    logic       rd_ptr;
    logic [1:0] count;
    logic       wr_ptr;
    logic       do_push;
    logic       do_pop;

    // With one entry held, a push lands in the other slot, so a same-cycle pop makes it head.
    assign wr_ptr  = rd_ptr ^ count[0];
    assign full    = (count == 2'd2);
    assign empty   = (count == 2'd0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = slots[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                slots[wr_ptr] <= push_entry;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    always_comb begin
        entry_valid = 2'b00;
        if (count == 2'd2) begin
            entry_valid = 2'b11;
        end else if (count == 2'd1) begin
            entry_valid[rd_ptr] = 1'b1;
        end
        entry_addr[0] = slots[0].addr;
        entry_addr[1] = slots[1].addr;
    end

endmodule

// File: rtl/rf_wb_write_arbiter.sv
// Register-file write-port sequencer: zero sweep after reset, then round-robin
// arbitration of N_REQ buffered writeback requesters with a per-address pending mask.
module rf_wb_write_arbiter
    import rf_wb_write_arbiter_pkg::*;
#(
    parameter int WIDTH = RF_WIDTH,
    parameter int N_REQ = 4,
    parameter int DEPTH = RF_DEPTH,
    localparam int AW   = $clog2(DEPTH),
    localparam int PW   = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*AW-1:0]    req_addr,
    input  logic [N_REQ*WIDTH-1:0] req_data,
    output logic                   ram_we,
    output logic [AW-1:0]          ram_waddr,
    output logic [WIDTH-1:0]       ram_wdata,
    output logic [DEPTH-1:0]       pending_mask,
    output logic                   init_busy,
    output logic                   idle
);

    rf_wb_state_e state;
    logic [AW-1:0] init_cnt;
    logic [PW-1:0] rr_ptr;

    logic [N_REQ-1:0]         full;
    logic [N_REQ-1:0]         empty;
    logic [N_REQ-1:0]         push;
    logic [N_REQ-1:0]         pop;
    rf_wb_req_t               head      [N_REQ];
    rf_wb_req_t               in_entry  [N_REQ];
    logic [1:0]               ent_valid [N_REQ];
    logic [1:0][RF_AW-1:0]    ent_addr  [N_REQ];

    logic          grant_valid;
    logic [PW-1:0] grant;

    for (genvar g = 0; g < N_REQ; g++) begin : g_fifo
        assign in_entry[g] = '{addr: req_addr[g*AW +: AW], data: req_data[g*WIDTH +: WIDTH]};
        assign req_ready[g] = (state == RF_WB_RUN) && !full[g];
        assign push[g]      = req_valid[g] && req_ready[g];

        rf_wb_fifo2 u_fifo (
            .clk         (clk),
            .rst         (rst),
            .push        (push[g]),
            .push_entry  (in_entry[g]),
            .pop         (pop[g]),
            .full        (full[g]),
            .empty       (empty[g]),
            .head        (head[g]),
            .entry_valid (ent_valid[g]),
            .entry_addr  (ent_addr[g])
        );
    end

    // First non-empty FIFO at or after rr_ptr, wrapping around.
    always_comb begin
        grant_valid = 1'b0;
        grant       = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!grant_valid && !empty[(int'(rr_ptr) + k) % N_REQ]) begin
                grant_valid = 1'b1;
                grant       = PW'((int'(rr_ptr) + k) % N_REQ);
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            pop[i] = (state == RF_WB_RUN) && grant_valid && (grant == PW'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RF_WB_INIT;
            init_cnt  <= '0;
            rr_ptr    <= '0;
            ram_we    <= 1'b0;
            ram_waddr <= '0;
            ram_wdata <= '0;
        end else begin
            case (state)
                RF_WB_INIT: begin
                    // Leave INIT only after the last sweep address has been on the port.
                    if (ram_we && ram_waddr == AW'(DEPTH - 1)) begin
                        state  <= RF_WB_RUN;
                        ram_we <= 1'b0;
                    end else begin
                        ram_we    <= 1'b1;
                        ram_waddr <= init_cnt;
                        ram_wdata <= '0;
                        init_cnt  <= init_cnt + 1'b1;
                    end
                end
                RF_WB_RUN: begin
                    if (grant_valid) begin
                        ram_we    <= 1'b1;
                        ram_waddr <= head[grant].addr;
                        ram_wdata <= head[grant].data;
                        rr_ptr    <= (grant == PW'(N_REQ - 1)) ? '0 : grant + 1'b1;
                    end else begin
                        ram_we <= 1'b0;
                    end
                end
                default: state <= RF_WB_INIT;
            endcase
        end
    end

    always_comb begin
        pending_mask = '0;
        for (int i = 0; i < N_REQ; i++) begin
            for (int e = 0; e < 2; e++) begin
                if (ent_valid[i][e]) begin
                    pending_mask = pending_mask | rf_addr_onehot(ent_addr[i][e]);
                end
            end
        end
        if (ram_we) begin
            pending_mask = pending_mask | rf_addr_onehot(ram_waddr);
        end
    end

    assign init_busy = (state == RF_WB_INIT);
    assign idle      = (state == RF_WB_RUN) && (&empty) && !ram_we;

    // Renaming guarantees no two requesters queue the same address at once.
    always @(posedge clk) begin
        if (!rst && state == RF_WB_RUN) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (req_valid[i]) begin
                    assert (int'(req_addr[i*AW +: AW]) < DEPTH);
                end
                for (int j = i + 1; j < N_REQ; j++) begin
                    for (int a = 0; a < 2; a++) begin
                        for (int b = 0; b < 2; b++) begin
                            if (ent_valid[i][a] && ent_valid[j][b]) begin
                                assert (ent_addr[i][a] != ent_addr[j][b]);
                            end
                        end
                    end
                end
            end
        end
    end

endmodule
